load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the data-memory port: accepts one load/store request at a time from the
//  pipeline, drives the byte-addressed, big-endian, word-wide data memory (combinational read,
//  write on CLK negedge, active-low MemRead/MemWrite), and returns a response.
//  Sub-word stores use read-modify-write; sub-word loads are lane-selected and extended.
// PARAMETERS
//  ADDR_LIMIT  60  highest valid byte address in data memory; any access touching a byte above it errors
// PORTS
//  CLK        in   1   clock, all state on rising edge
//  RST        in   1   synchronous reset, active-low
//  ReqValid   in   1   request present
//  Ready      out  1   unit idle, request accepted when ReqValid&&Ready
//  ReqStore   in   1   1=store, 0=load
//  ReqSize    in   2   00 byte, 01 half, 10 word, 11 reserved
//  ReqUnsign  in   1   1=zero-extend load (lbu/lhu); ignored for stores
//  ReqAddr    in   32  byte address
//  ReqWData   in   32  store data, right-justified for sb/sh
//  RespValid  out  1   response held until RespReady
//  RespReady  in   1   consumer takes response
//  RespData   out  32  load result (extended); 0 for stores and errors
//  RespErr    out  1   misaligned, reserved size, or out-of-range; no memory access was made
//  Address    out  32  to memory, always word-aligned {ReqAddr[31:2],2'b00}
//  WriteData  out  32  to memory
//  MemRead    out  1   active-low read enable
//  MemWrite   out  1   active-low write enable
//  ReadData   in   32  from memory, valid only while MemRead=0 (Z otherwise)
// BEHAVIOUR
//  Reset/idle outputs: Ready=1, RespValid=0, RespData=0, RespErr=0, Address=0, WriteData=0, MemRead=1, MemWrite=1.
//  FSM: IDLE -> {RD, WR, RESP}; RD -> {WR (sub-word store), RESP}; WR -> RESP; RESP -> IDLE on RespReady.
//  Accept (cycle T, IDLE): latch Store/Size/Unsign/Addr/WData. Error check in accept cycle:
//   size 11; half with Addr[0]=1; word with Addr[1:0]!=0; {Addr[31:2],2'b00}+3 > ADDR_LIMIT -> RESP at T+1, RespErr=1.
//  RD: MemRead=0, Address driven; ReadData captured at end of cycle. Load -> RESP at T+2.
//  WR: MemWrite=0 for exactly one cycle; lw-sw: WriteData=ReqWData, RESP at T+2.
//   sb/sh: WriteData = captured word with selected lane replaced, RESP at T+3.
//  Lanes (big-endian): byte offset k -> bits [31-8k -: 8]; half offset 0 -> [31:16], offset 2 -> [15:0].
//  Load extend: sign-extend unless ReqUnsign=1; lw passes word unchanged.
//  MemRead and MemWrite never both 0 in one cycle; both 1 outside RD/WR.
//  Ready=1 only in IDLE; ReqValid outside IDLE ignored. Response accepted in RESP cycle -> IDLE next
//   cycle; earliest next accept is one cycle after the response is taken (one-cycle bubble).
//  RespValid/RespData/RespErr stable while RespValid=1 and RespReady=0.
//  Reset mid-operation: RST=0 sampled at a rising edge forces IDLE and idle outputs next cycle; a WR
//   cycle already in progress completes its negedge write; no response is produced for the aborted request.
// STRUCTURE
//  Package lsu_pkg: SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_RSVD, state encodings ST_IDLE/ST_RD/ST_WR/ST_RESP.
//  Sub-module lsu_lane (combinational): inputs word, offset[1:0], size, unsigned, store data;
//   outputs extended load value and merged store word. FSM and registers stay in load_store_unit.
// TESTING
//  Memory model: 61-byte big-endian, writes on negedge, Z when MemRead=1; ADDR_LIMIT=60.
//  lw addr 8, mem[8..11]=12 34 56 78 -> RespData=32'h12345678 at T+2, one MemRead=0 cycle, no MemWrite=0.
//  lb addr 9 with mem[9]=8'h84 -> 32'hFFFFFF84; lbu same -> 32'h00000084; lh addr 10 mem=80 01 -> 32'hFFFF8001.
//  sb addr 13 data 32'hAA over word 32'h11223344 at 12 -> one RD then one WR of 32'h11AA3344, RESP at T+3.
//  lh addr 3, lw addr 6, size 11, lw addr 60 -> RespErr=1 at T+1, MemRead/MemWrite never 0.
//  Hold RespReady=0 for 5 cycles -> RespValid/RespData stable, Ready=0, ReqValid ignored; then release.
//  RST=0 during RD of sh -> IDLE next cycle, no WR cycle issued, no RespValid; memory unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the data-memory load/store unit.
//   size_e  - request size encodings (byte, half, word, reserved)
//   state_e - load_store_unit FSM states
//   req_error() - accept-cycle check for reserved size, misalignment and range
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  // Range is judged on the whole containing word, so a byte access near the
  // top can fail even when its own byte would be in range.
  function automatic logic req_error(input size_e       size,
                                     input logic [31:0] addr,
                                     input logic [31:0] limit);
    logic [31:0] last_byte;
    last_byte = {addr[31:2], 2'b00} + 32'd3;
    req_error = (size == SIZE_RSVD)
             || ((size == SIZE_HALF) && addr[0])
             || ((size == SIZE_WORD) && (addr[1:0] != 2'b00))
             || (last_byte > limit);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// lsu_lane: combinational big-endian lane logic.
//   word_i     - word read from memory
//   offset_i   - byte offset within the word (ReqAddr[1:0])
//   size_i     - access size (lsu_pkg::size_e encoding)
//   unsigned_i - zero-extend loads when set
//   store_i    - right-justified store data
//   load_o     - selected and extended load value
//   merged_o   - word to write back (lane replaced for sub-word stores)
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] store_i,
  output logic [31:0] load_o,
  output logic [31:0] merged_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v   = 8'h00;
    half_v   = 16'h0000;
    load_o   = '0;
    merged_o = word_i;

    // Offset 0 is the most significant byte.
    case (offset_i)
      2'd0:    byte_v = word_i[31:24];
      2'd1:    byte_v = word_i[23:16];
      2'd2:    byte_v = word_i[15:8];
      default: byte_v = word_i[7:0];
    endcase
    half_v = offset_i[1] ? word_i[15:0] : word_i[31:16];

    case (size_i)
      SIZE_BYTE: begin
        load_o = {{24{byte_v[7] & ~unsigned_i}}, byte_v};
        case (offset_i)
          2'd0:    merged_o[31:24] = store_i[7:0];
          2'd1:    merged_o[23:16] = store_i[7:0];
          2'd2:    merged_o[15:8]  = store_i[7:0];
          default: merged_o[7:0]   = store_i[7:0];
        endcase
      end
      SIZE_HALF: begin
        load_o = {{16{half_v[15] & ~unsigned_i}}, half_v};
        if (offset_i[1]) merged_o[15:0]  = store_i[15:0];
        else             merged_o[31:16] = store_i[15:0];
      end
      default: begin
        load_o   = word_i;
        merged_o = store_i;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory port.
// Accepts one load/store at a time, drives a word-wide big-endian memory with
// active-low MemRead/MemWrite, and holds a response until RespReady.
//   CLK, RST         - clock, synchronous active-low reset
//   ReqValid/Ready   - request handshake; ReqStore/ReqSize/ReqUnsign/ReqAddr/ReqWData
//   RespValid/Ready  - response handshake; RespData, RespErr
//   Address, WriteData, MemRead, MemWrite, ReadData - memory port
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = 60
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ReqValid,
  output logic        Ready,
  input  logic        ReqStore,
  input  logic [1:0]  ReqSize,
  input  logic        ReqUnsign,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RespValid,
  input  logic        RespReady,
  output logic [31:0] RespData,
  output logic        RespErr,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] ReadData
);

  state_e      state_q, state_d;
  logic        store_q;
  size_e       size_q;
  logic        unsign_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;

  logic        accept;
  logic        req_err;
  logic [31:0] lane_load;
  logic [31:0] lane_merged;

  assign req_err = req_error(size_e'(ReqSize), ReqAddr, ADDR_LIMIT);

  // The raw word is kept in rdata_q; both the load result (in RESP) and the
  // read-modify-write word (in WR) are derived from it, so RespData stays
  // stable while the response is held.
  lsu_lane u_lane (
    .word_i     (rdata_q),
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .unsigned_i (unsign_q),
    .store_i    (wdata_q),
    .load_o     (lane_load),
    .merged_o   (lane_merged)
  );

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      store_q  <= 1'b0;
      size_q   <= SIZE_BYTE;
      unsign_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        store_q  <= ReqStore;
        size_q   <= size_e'(ReqSize);
        unsign_q <= ReqUnsign;
        addr_q   <= ReqAddr;
        wdata_q  <= ReqWData;
        err_q    <= req_err;
      end
      if (state_q == ST_RD) begin
        rdata_q <= ReadData;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    Ready     = 1'b0;
    RespValid = 1'b0;
    RespData  = '0;
    RespErr   = 1'b0;
    Address   = '0;
    WriteData = '0;
    MemRead   = 1'b1;
    MemWrite  = 1'b1;

    case (state_q)
      ST_IDLE: begin
        Ready = 1'b1;
        if (ReqValid) begin
          accept = 1'b1;
          if (req_err)
            state_d = ST_RESP;
          else if (ReqStore && (ReqSize == SIZE_WORD))
            state_d = ST_WR;
          else
            state_d = ST_RD;
        end
      end
      ST_RD: begin
        MemRead = 1'b0;
        Address = {addr_q[31:2], 2'b00};
        state_d = store_q ? ST_WR : ST_RESP;
      end
      ST_WR: begin
        MemWrite  = 1'b0;
        Address   = {addr_q[31:2], 2'b00};
        WriteData = lane_merged;
        state_d   = ST_RESP;
      end
      default: begin
        RespValid = 1'b1;
        RespErr   = err_q;
        RespData  = (err_q || store_q) ? '0 : lane_load;
        if (RespReady) state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit with a
// 61-byte big-endian memory model (negedge writes, combinational reads).
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ReqValid = 1'b0;
  logic        Ready;
  logic        ReqStore = 1'b0;
  logic [1:0]  ReqSize = 2'b00;
  logic        ReqUnsign = 1'b0;
  logic [31:0] ReqAddr = '0;
  logic [31:0] ReqWData = '0;
  logic        RespValid;
  logic        RespReady = 1'b0;
  logic [31:0] RespData;
  logic        RespErr;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  load_store_unit #(.ADDR_LIMIT(60)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ReqValid  (ReqValid),
    .Ready     (Ready),
    .ReqStore  (ReqStore),
    .ReqSize   (ReqSize),
    .ReqUnsign (ReqUnsign),
    .ReqAddr   (ReqAddr),
    .ReqWData  (ReqWData),
    .RespValid (RespValid),
    .RespReady (RespReady),
    .RespData  (RespData),
    .RespErr   (RespErr),
    .Address   (Address),
    .WriteData (WriteData),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .ReadData  (ReadData)
  );

  // Memory: bytes 8..15 hold 12 34 56 78 11 22 33 44, 56..59 hold 01 02 03 04,
  // everything else 5A.
  logic [7:0] mem [0:60] = '{8: 8'h12, 9: 8'h34, 10: 8'h56, 11: 8'h78,
                             12: 8'h11, 13: 8'h22, 14: 8'h33, 15: 8'h44,
                             56: 8'h01, 57: 8'h02, 58: 8'h03, 59: 8'h04,
                             default: 8'h5A};
  logic [31:0] rd_word;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;
  int rd_cycles = 0;
  int wr_cycles = 0;
  int both_low  = 0;

  always_comb begin
    int unsigned a;
    a = Address;
    rd_word = 32'hBAD0BAD0;
    if (a + 3 <= 60) rd_word = {mem[a], mem[a+1], mem[a+2], mem[a+3]};
  end
  // A recognisable pattern stands in for the undriven bus when MemRead=1.
  assign ReadData = MemRead ? 32'hDEADBEEF : rd_word;

  always @(negedge CLK) begin
    if (!MemWrite) begin
      int unsigned a;
      a = Address;
      last_waddr <= Address;
      last_wdata <= WriteData;
      if (a + 3 <= 60) begin
        mem[a]   <= WriteData[31:24];
        mem[a+1] <= WriteData[23:16];
        mem[a+2] <= WriteData[15:8];
        mem[a+3] <= WriteData[7:0];
      end
    end
  end

  always @(posedge CLK) begin
    if (!MemRead) rd_cycles <= rd_cycles + 1;
    if (!MemWrite) wr_cycles <= wr_cycles + 1;
    if (!MemRead && !MemWrite) both_low <= both_low + 1;
  end

  // Issues one request starting #1 after a rising edge in IDLE and takes the
  // response; lat counts rising edges from the accept edge to RespValid.
  task automatic run_req(input logic st, input logic [1:0] sz, input logic un,
                         input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] data, output logic err,
                         output int lat, output int nrd, output int nwr,
                         output logic rdy0);
    int rd0, wr0;
    rdy0 = Ready;
    rd0 = rd_cycles;
    wr0 = wr_cycles;
    ReqValid = 1'b1; ReqStore = st; ReqSize = sz; ReqUnsign = un;
    ReqAddr = a; ReqWData = wd;
    @(posedge CLK); #1;
    ReqValid = 1'b0;
    lat = 1;
    while (!RespValid && lat < 8) begin
      @(posedge CLK); #1;
      lat++;
    end
    data = RespData;
    err = RespErr;
    RespReady = 1'b1;
    @(posedge CLK); #1;
    RespReady = 1'b0;
    nrd = rd_cycles - rd0;
    nwr = wr_cycles - wr0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (Ready !== 1'b1 || RespValid !== 1'b0 || RespErr !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake Ready=%b RespValid=%b RespErr=%b required 1 0 0", Ready, RespValid, RespErr);
    end
    checks++;
    if (RespData !== 32'h0 || Address !== 32'h0 || WriteData !== 32'h0) begin
      errors++;
      $display("FAIL reset_buses RespData=%h Address=%h WriteData=%h required all 0", RespData, Address, WriteData);
    end
    checks++;
    if (MemRead !== 1'b1 || MemWrite !== 1'b1) begin
      errors++;
      $display("FAIL reset_strobes MemRead=%b MemWrite=%b required 1 1", MemRead, MemWrite);
    end
    RST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_lw();
    logic [31:0] d; logic e; int lat, nrd, nwr; logic r0;
    run_req(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, d, e, lat, nrd, nwr, r0);
    checks++;
    if (d !== 32'h12345678 || e !== 1'b0) begin
      errors++;
      $display("FAIL lw8_data got %h err %b required 12345678 err 0", d, e);
    end
    checks++;
    if (lat != 2 || nrd != 1 || nwr != 0) begin
      errors++;
      $display("FAIL lw8_timing lat %0d rd %0d wr %0d required 2 1 0", lat, nrd, nwr);
    end
  endtask

  task automatic test_stores();
    logic [31:0] d; logic e; int lat, nrd, nwr; logic r0;
    run_req(1'b1, 2'b00, 1'b0, 32'd13, 32'h123456AA, d, e, lat, nrd, nwr, r0);
    checks++;
    if (last_wdata !== 32'h11AA3344 || last_waddr !== 32'd12) begin
      errors++;
      $display("FAIL sb13_write got %h at %0d required 11aa3344 at 12", last_wdata, last_waddr);
    end
    checks++;
    if (lat != 3 || nrd != 1 || nwr != 1 || d !== 32'h0 || e !== 1'b0) begin
      errors++;
      $display("FAIL sb13_resp lat %0d rd %0d wr %0d data %h err %b required 3 1 1 0 0", lat, nrd, nwr, d, e);
    end
    run_req(1'b1, 2'b00, 1'b0, 32'd9, 32'h00000084, d, e, lat, nrd, nwr, r0);
    checks++;
    if (last_wdata !== 32'h12845678) begin
      errors++;
      $display("FAIL sb9_write got %h required 12845678", last_wdata);
    end
    run_req(1'b1, 2'b01, 1'b0, 32'd10, 32'hFFFF8001, d, e, lat, nrd, nwr, r0);
    checks++;
    if (last_wdata !== 32'h12848001 || lat != 3) begin
      errors++;
      $display("FAIL sh10_write got %h lat %0d required 12848001 lat 3", last_wdata, lat);
    end
    run_req(1'b1, 2'b00, 1'b0, 32'd15, 32'h000000EE, d, e, lat, nrd, nwr, r0);
    checks++;
    if (last_wdata !== 32'h11AA33EE) begin
      errors++;
      $display("FAIL sb15_write got %h required 11aa33ee", last_wdata);
    end
    run_req(1'b1, 2'b01, 1'b0, 32'd12, 32'h0000BEEF, d, e, lat, nrd, nwr, r0);
    checks++;
    if (last_wdata !== 32'hBEEF33EE) begin
      errors++;
      $display("FAIL sh12_write got %h required beef33ee", last_wdata);
    end
    run_req(1'b1, 2'b10, 1'b0, 32'd16, 32'hCAFEF00D, d, e, lat, nrd, nwr, r0);
    checks++;
    if (last_wdata !== 32'hCAFEF00D || last_waddr !== 32'd16 || lat != 2 || nrd != 0 || nwr != 1) begin
      errors++;
      $display("FAIL sw16 wrote %h at %0d lat %0d rd %0d wr %0d required cafef00d 16 2 0 1",
               last_wdata, last_waddr, lat, nrd, nwr);
    end
  endtask

  task automatic test_loads();
    logic [31:0] d; logic e; int lat, nrd, nwr; logic r0;
    // mem[8..11]=12 84 80 01, mem[12..15]=BE EF 33 EE, mem[16..19]=CA FE F0 0D
    logic [31:0] addr_t [9] = '{32'd9, 32'd9, 32'd10, 32'd10, 32'd8, 32'd8, 32'd15, 32'd10, 32'd12};
    logic [1:0]  size_t [9] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01};
    logic        uns_t  [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] exp_t  [9] = '{32'hFFFFFF84, 32'h00000084, 32'hFFFF8001, 32'h00008001,
                                32'h00000012, 32'h00001284, 32'hFFFFFFEE, 32'hFFFFFF80,
                                32'h0000BEEF};
    for (int i = 0; i < 9; i++) begin
      run_req(1'b0, size_t[i], uns_t[i], addr_t[i], 32'hFFFFFFFF, d, e, lat, nrd, nwr, r0);
      checks++;
      if (d !== exp_t[i] || e !== 1'b0 || lat != 2 || nwr != 0) begin
        errors++;
        $display("FAIL load_%0d addr %0d got %h err %b lat %0d wr %0d required %h 0 2 0",
                 i, addr_t[i], d, e, lat, nwr, exp_t[i]);
      end
    end
    run_req(1'b0, 2'b10, 1'b0, 32'd16, 32'h0, d, e, lat, nrd, nwr, r0);
    checks++;
    if (d !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL lw16 got %h required cafef00d", d);
    end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int lat, nrd, nwr; logic r0;
    logic        st_t   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  size_t [7] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b00, 2'b10, 2'b01};
    logic [31:0] addr_t [7] = '{32'd3, 32'd6, 32'd0, 32'd60, 32'd60, 32'd60, 32'd9};
    for (int i = 0; i < 7; i++) begin
      run_req(st_t[i], size_t[i], 1'b0, addr_t[i], 32'h55555555, d, e, lat, nrd, nwr, r0);
      checks++;
      if (e !== 1'b1 || d !== 32'h0 || lat != 1 || nrd != 0 || nwr != 0) begin
        errors++;
        $display("FAIL err_%0d addr %0d err %b data %h lat %0d rd %0d wr %0d required 1 0 1 0 0",
                 i, addr_t[i], e, d, lat, nrd, nwr);
      end
    end
    run_req(1'b0, 2'b10, 1'b0, 32'd56, 32'h0, d, e, lat, nrd, nwr, r0);
    checks++;
    if (d !== 32'h01020304 || e !== 1'b0) begin
      errors++;
      $display("FAIL lw56_edge got %h err %b required 01020304 0", d, e);
    end
    run_req(1'b0, 2'b00, 1'b1, 32'd59, 32'h0, d, e, lat, nrd, nwr, r0);
    checks++;
    if (d !== 32'h00000004 || e !== 1'b0) begin
      errors++;
      $display("FAIL lbu59_edge got %h err %b required 00000004 0", d, e);
    end
  endtask

  task automatic test_backpressure();
    int lat, wr0;
    wr0 = wr_cycles;
    ReqValid = 1'b1; ReqStore = 1'b0; ReqSize = 2'b10; ReqUnsign = 1'b0; ReqAddr = 32'd8;
    @(posedge CLK); #1;
    ReqValid = 1'b0;
    lat = 1;
    while (!RespValid && lat < 8) begin
      @(posedge CLK); #1;
      lat++;
    end
    checks++;
    if (lat != 2) begin
      errors++;
      $display("FAIL hold_first_resp lat %0d required 2", lat);
    end
    for (int i = 0; i < 5; i++) begin
      ReqValid = 1'b1; ReqStore = 1'b1; ReqSize = 2'b10; ReqAddr = 32'd24; ReqWData = 32'hFFFFFFFF;
      @(posedge CLK); #1;
      checks++;
      if (RespValid !== 1'b1 || RespData !== 32'h12848001 || RespErr !== 1'b0 || Ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle_%0d RespValid %b RespData %h RespErr %b Ready %b required 1 12848001 0 0",
                 i, RespValid, RespData, RespErr, Ready);
      end
    end
    ReqValid = 1'b0;
    RespReady = 1'b1;
    @(posedge CLK); #1;
    RespReady = 1'b0;
    checks++;
    if (Ready !== 1'b1 || RespValid !== 1'b0 || (wr_cycles - wr0) != 0) begin
      errors++;
      $display("FAIL hold_release Ready %b RespValid %b writes %0d required 1 0 0",
               Ready, RespValid, wr_cycles - wr0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; int lat, nrd, nwr; logic r0;
    run_req(1'b0, 2'b00, 1'b1, 32'd17, 32'h0, d, e, lat, nrd, nwr, r0);
    run_req(1'b0, 2'b00, 1'b1, 32'd18, 32'h0, d, e, lat, nrd, nwr, r0);
    checks++;
    if (r0 !== 1'b1 || d !== 32'h000000F0 || lat != 2) begin
      errors++;
      $display("FAIL back_to_back ready %b data %h lat %0d required 1 000000f0 2", r0, d, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; int lat, nrd, nwr; logic r0;
    int wr0, seen;
    wr0 = wr_cycles;
    ReqValid = 1'b1; ReqStore = 1'b1; ReqSize = 2'b01; ReqAddr = 32'd20; ReqWData = 32'h00007777;
    @(posedge CLK); #1;
    ReqValid = 1'b0;
    checks++;
    if (MemRead !== 1'b0) begin
      errors++;
      $display("FAIL midrst_in_rd MemRead %b required 0", MemRead);
    end
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (Ready !== 1'b1 || MemRead !== 1'b1 || MemWrite !== 1'b1 || RespValid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_idle Ready %b MemRead %b MemWrite %b RespValid %b required 1 1 1 0",
               Ready, MemRead, MemWrite, RespValid);
    end
    RST = 1'b1;
    seen = 0;
    repeat (3) begin
      @(posedge CLK); #1;
      if (RespValid) seen++;
    end
    checks++;
    if (seen != 0 || (wr_cycles - wr0) != 0) begin
      errors++;
      $display("FAIL midrst_quiet resp %0d writes %0d required 0 0", seen, wr_cycles - wr0);
    end
    run_req(1'b0, 2'b10, 1'b0, 32'd20, 32'h0, d, e, lat, nrd, nwr, r0);
    checks++;
    if (d !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL midrst_mem got %h required 5a5a5a5a", d);
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_stores();
    test_loads();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if (both_low != 0) begin
      errors++;
      $display("FAIL strobes_exclusive both-low cycles %0d required 0", both_low);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exceeded 200000 required completion");
    $fatal(1);
  end

endmodule
